// File: rtl/wall_round_sequencer.sv
// Game-level sequencer for the hole-in-the-wall datapath: countdown, wall approach, judging, result and game over.
// Optional build macro PAUSE_EN adds pause_in, which freezes all frame-driven progress while high.
module wall_round_sequencer #(
  parameter int unsigned GOAL_DEPTH               = 60,
  parameter int unsigned GOAL_DEPTH_DELTA         = 10,
  parameter int unsigned MAX_WALL_DEPTH           = 75,
  parameter int unsigned MAX_FRAMES_PER_WALL_TICK = 15,
  parameter int unsigned MIN_FRAMES_PER_WALL_TICK = 3,
  parameter int unsigned ROUNDS_PER_LEVEL         = 3,
  parameter int unsigned NUM_WALLS                = 10,
  parameter int unsigned START_LIVES              = 3,
  parameter int unsigned COUNTDOWN_FRAMES         = 180,
  parameter int unsigned RESULT_FRAMES            = 60,
  parameter int unsigned COLLISION_THRESH         = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       new_frame_in,
  input  logic       collision_in,
`ifdef PAUSE_EN
  input  logic       pause_in,
`endif
  output logic [7:0] wall_depth_out,
  output logic [3:0] wall_idx_out,
  output logic       wall_visible_out,
  output logic       judge_window_out,
  output logic [3:0] frames_per_tick_out,
  output logic [7:0] score_out,
  output logic [1:0] lives_out,
  output logic [7:0] round_out,
  output logic [2:0] game_state_out,
  output logic       round_pass_pulse_out,
  output logic       round_fail_pulse_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    ADVANCE   = 3'd2,
    RESULT    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [7:0]  WIN_LO     = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
  localparam logic [7:0]  WIN_HI     = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
  localparam logic [7:0]  LAST_DEPTH = 8'(MAX_WALL_DEPTH - 1);
  localparam logic [3:0]  FPT_MAX    = 4'(MAX_FRAMES_PER_WALL_TICK);
  localparam logic [3:0]  FPT_MIN    = 4'(MIN_FRAMES_PER_WALL_TICK);
  localparam logic [7:0]  LVL_LAST   = 8'(ROUNDS_PER_LEVEL - 1);
  localparam logic [3:0]  IDX_LAST   = 4'(NUM_WALLS - 1);
  localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0]  CD_LAST    = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0]  RES_LAST   = 8'(RESULT_FRAMES - 1);
  localparam logic [15:0] HIT_THRESH = 16'(COLLISION_THRESH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  function automatic logic [1:0] dec_lives(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  function automatic logic [3:0] dec_fpt(input logic [3:0] v);
    return (v <= FPT_MIN) ? FPT_MIN : v - 4'd1;
  endfunction

  function automatic logic in_window(input logic [7:0] d);
    return (d >= WIN_LO) && (d <= WIN_HI);
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  depth, depth_nxt;
  logic [3:0]  tick, tick_nxt;
  logic [3:0]  fpt, fpt_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [7:0]  score, score_nxt;
  logic [1:0]  lives, lives_nxt;
  logic [7:0]  round_cnt, round_nxt;
  logic [7:0]  lvl_cnt, lvl_nxt;
  logic [7:0]  frame_cnt, frame_nxt;
  logic [15:0] coll_cnt, coll_nxt, coll_sum;
  logic        hit, hit_nxt, hit_now;
  logic        pass_p, pass_nxt, fail_p, fail_nxt;
  logic        visible, visible_nxt, judge, judge_nxt;
  logic        freeze, frame, coll;

`ifdef PAUSE_EN
  assign freeze = pause_in && (state == COUNTDOWN || state == ADVANCE || state == RESULT);
`else
  assign freeze = 1'b0;
`endif

  assign frame    = new_frame_in && !freeze;
  assign coll     = collision_in && !freeze && (state == ADVANCE) && in_window(depth);
  assign coll_sum = sat_inc16(coll_cnt, coll);

  always_comb begin
    state_nxt = state;
    depth_nxt = depth;
    tick_nxt  = tick;
    fpt_nxt   = fpt;
    idx_nxt   = idx;
    score_nxt = score;
    lives_nxt = lives;
    round_nxt = round_cnt;
    lvl_nxt   = lvl_cnt;
    frame_nxt = frame_cnt;
    coll_nxt  = coll_cnt;
    hit_nxt   = hit;
    hit_now   = hit;
    pass_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    case (state)
      IDLE, GAME_OVER: begin
        if (start_in) begin
          state_nxt = COUNTDOWN;
          score_nxt = 8'd0;
          lives_nxt = LIVES_INIT;
          round_nxt = 8'd0;
          idx_nxt   = 4'd0;
          fpt_nxt   = FPT_MAX;
          lvl_nxt   = 8'd0;
          frame_nxt = 8'd0;
        end
      end
      COUNTDOWN: begin
        if (frame) begin
          if (frame_cnt == CD_LAST) begin
            state_nxt = ADVANCE;
            frame_nxt = 8'd0;
            depth_nxt = 8'd0;
            tick_nxt  = 4'd0;
            hit_nxt   = 1'b0;
            coll_nxt  = 16'd0;
          end else begin
            frame_nxt = frame_cnt + 8'd1;
          end
        end
      end
      ADVANCE: begin
        coll_nxt = coll_sum;
        if (frame) begin
          // The collision arriving with the frame strobe still counts toward this frame
          hit_now  = hit || (coll_sum >= HIT_THRESH);
          hit_nxt  = hit_now;
          coll_nxt = 16'd0;
          if (tick == fpt - 4'd1) begin
            tick_nxt  = 4'd0;
            depth_nxt = depth + 8'd1;
            if (depth + 8'd1 == LAST_DEPTH) begin
              state_nxt = RESULT;
              frame_nxt = 8'd0;
              round_nxt = round_cnt + 8'd1;
              idx_nxt   = (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
              if (hit_now) begin
                fail_nxt  = 1'b1;
                lives_nxt = dec_lives(lives);
              end else begin
                pass_nxt  = 1'b1;
                score_nxt = sat_inc8(score);
                if (lvl_cnt == LVL_LAST) begin
                  lvl_nxt = 8'd0;
                  fpt_nxt = dec_fpt(fpt);
                end else begin
                  lvl_nxt = lvl_cnt + 8'd1;
                end
              end
            end
          end else begin
            tick_nxt = tick + 4'd1;
          end
        end
      end
      RESULT: begin
        if (frame) begin
          if (frame_cnt == RES_LAST) begin
            frame_nxt = 8'd0;
            if (lives == 2'd0) begin
              state_nxt = GAME_OVER;
            end else begin
              state_nxt = ADVANCE;
              depth_nxt = 8'd0;
              tick_nxt  = 4'd0;
              hit_nxt   = 1'b0;
              coll_nxt  = 16'd0;
            end
          end else begin
            frame_nxt = frame_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    visible_nxt = (state_nxt == ADVANCE);
    judge_nxt   = in_window(depth_nxt);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      depth     <= 8'd0;
      tick      <= 4'd0;
      fpt       <= FPT_MAX;
      idx       <= 4'd0;
      score     <= 8'd0;
      lives     <= LIVES_INIT;
      round_cnt <= 8'd0;
      lvl_cnt   <= 8'd0;
      frame_cnt <= 8'd0;
      coll_cnt  <= 16'd0;
      hit       <= 1'b0;
      pass_p    <= 1'b0;
      fail_p    <= 1'b0;
      visible   <= 1'b0;
      judge     <= 1'b0;
    end else begin
      state     <= state_nxt;
      depth     <= depth_nxt;
      tick      <= tick_nxt;
      fpt       <= fpt_nxt;
      idx       <= idx_nxt;
      score     <= score_nxt;
      lives     <= lives_nxt;
      round_cnt <= round_nxt;
      lvl_cnt   <= lvl_nxt;
      frame_cnt <= frame_nxt;
      coll_cnt  <= coll_nxt;
      hit       <= hit_nxt;
      pass_p    <= pass_nxt;
      fail_p    <= fail_nxt;
      visible   <= visible_nxt;
      judge     <= judge_nxt;
    end
  end

  assign wall_depth_out       = depth;
  assign wall_idx_out         = idx;
  assign wall_visible_out     = visible;
  assign judge_window_out     = judge;
  assign frames_per_tick_out  = fpt;
  assign score_out            = score;
  assign lives_out            = lives;
  assign round_out            = round_cnt;
  assign game_state_out       = state;
  assign round_pass_pulse_out = pass_p;
  assign round_fail_pulse_out = fail_p;

endmodule

// File: tb/tb_wall_round_sequencer.sv
// Randomized bench for wall_round_sequencer against a frame-level game model kept in the bench.
module tb_wall_round_sequencer;

  localparam int CDF   = 2;
  localparam int FPTMX = 4;
  localparam int FPTMN = 2;
  localparam int RESF  = 2;
  localparam int RPL   = 3;
  localparam int NW    = 10;
  localparam int MAXD  = 75;
  localparam int WLO   = 50;
  localparam int WHI   = 70;
  localparam int TH    = 64;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       start_in = 1'b0;
  logic       new_frame_in = 1'b0;
  logic       collision_in = 1'b0;
  logic       pause_in = 1'b0;
  logic [7:0] wall_depth_out;
  logic [3:0] wall_idx_out;
  logic       wall_visible_out;
  logic       judge_window_out;
  logic [3:0] frames_per_tick_out;
  logic [7:0] score_out;
  logic [1:0] lives_out;
  logic [7:0] round_out;
  logic [2:0] game_state_out;
  logic       round_pass_pulse_out;
  logic       round_fail_pulse_out;

  wall_round_sequencer #(
    .MAX_FRAMES_PER_WALL_TICK(FPTMX),
    .MIN_FRAMES_PER_WALL_TICK(FPTMN),
    .COUNTDOWN_FRAMES(CDF),
    .RESULT_FRAMES(RESF)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .new_frame_in(new_frame_in),
    .collision_in(collision_in),
`ifdef PAUSE_EN
    .pause_in(pause_in),
`endif
    .wall_depth_out(wall_depth_out),
    .wall_idx_out(wall_idx_out),
    .wall_visible_out(wall_visible_out),
    .judge_window_out(judge_window_out),
    .frames_per_tick_out(frames_per_tick_out),
    .score_out(score_out),
    .lives_out(lives_out),
    .round_out(round_out),
    .game_state_out(game_state_out),
    .round_pass_pulse_out(round_pass_pulse_out),
    .round_fail_pulse_out(round_fail_pulse_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pass_seen = 0;
  int n_fail_seen = 0;

  // Game model: states 0 idle, 1 countdown, 2 advance, 3 result, 4 game over
  int m_state, m_depth, m_tick, m_fpt, m_idx, m_score, m_lives, m_round, m_lvl, m_fcnt, m_ccnt;
  bit m_hit, m_pass, m_fail, m_vis, m_win;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_win(input int d);
    return (d >= WLO) && (d <= WHI);
  endfunction

  task automatic model_reset();
    m_state = 0; m_depth = 0; m_tick = 0; m_fpt = FPTMX; m_idx = 0; m_score = 0;
    m_lives = 3; m_round = 0; m_lvl = 0; m_fcnt = 0; m_ccnt = 0;
    m_hit = 0; m_pass = 0; m_fail = 0; m_vis = 0; m_win = 0;
  endtask

  task automatic model_step(input bit s, input bit f, input bit c, input bit p);
    int cnt;
    if (p && (m_state == 1 || m_state == 2 || m_state == 3)) begin
      f = 0;
      c = 0;
    end
    m_pass = 0;
    m_fail = 0;
    case (m_state)
      0, 4: if (s) begin
        m_state = 1; m_score = 0; m_lives = 3; m_round = 0; m_idx = 0;
        m_fpt = FPTMX; m_lvl = 0; m_fcnt = 0;
      end
      1: if (f) begin
        m_fcnt++;
        if (m_fcnt == CDF) begin
          m_state = 2; m_fcnt = 0; m_depth = 0; m_tick = 0; m_hit = 0; m_ccnt = 0;
        end
      end
      2: begin
        cnt = m_ccnt + ((c && in_win(m_depth)) ? 1 : 0);
        if (cnt > 65535) cnt = 65535;
        if (f) begin
          if (cnt >= TH) m_hit = 1;
          m_ccnt = 0;
          if (m_tick == m_fpt - 1) begin
            m_tick = 0;
            m_depth++;
            if (m_depth == MAXD - 1) begin
              m_state = 3; m_fcnt = 0;
              m_round = (m_round + 1) % 256;
              m_idx = (m_idx + 1) % NW;
              if (m_hit) begin
                m_fail = 1;
                if (m_lives > 0) m_lives--;
              end else begin
                m_pass = 1;
                if (m_score < 255) m_score++;
                m_lvl++;
                if (m_lvl == RPL) begin
                  m_lvl = 0;
                  if (m_fpt > FPTMN) m_fpt--;
                end
              end
            end
          end else begin
            m_tick++;
          end
        end else begin
          m_ccnt = cnt;
        end
      end
      3: if (f) begin
        m_fcnt++;
        if (m_fcnt == RESF) begin
          m_fcnt = 0;
          if (m_lives == 0) m_state = 4;
          else begin
            m_state = 2; m_depth = 0; m_tick = 0; m_hit = 0; m_ccnt = 0;
          end
        end
      end
      default: m_state = 0;
    endcase
    m_vis = (m_state == 2);
    m_win = in_win(m_depth);
  endtask

  task automatic check_all();
    check("state", int'(game_state_out), m_state);
    check("depth", int'(wall_depth_out), m_depth);
    check("idx", int'(wall_idx_out), m_idx);
    check("visible", int'(wall_visible_out), int'(m_vis));
    check("judge", int'(judge_window_out), int'(m_win));
    check("fpt", int'(frames_per_tick_out), m_fpt);
    check("score", int'(score_out), m_score);
    check("lives", int'(lives_out), m_lives);
    check("round", int'(round_out), m_round);
    check("pass_pulse", int'(round_pass_pulse_out), int'(m_pass));
    check("fail_pulse", int'(round_fail_pulse_out), int'(m_fail));
  endtask

  task automatic cyc(input bit s, input bit f, input bit c);
    start_in = s;
    new_frame_in = f;
    collision_in = c;
    @(posedge clk_in);
    model_step(s, f, c, pause_in);
    #1;
    check_all();
    n_pass_seen += int'(round_pass_pulse_out);
    n_fail_seen += int'(round_fail_pulse_out);
    @(negedge clk_in);
    start_in = 0;
    new_frame_in = 0;
    collision_in = 0;
  endtask

  // One frame of len cycles; the last ncoll cycles (including the strobe cycle) carry collisions
  task automatic send_frame(input int len, input int ncoll, input bit rnd_start);
    for (int i = 0; i < len; i++)
      cyc(rnd_start && ($urandom_range(0, 15) == 0), i == len - 1, i >= len - ncoll);
  endtask

  task automatic noise_frame(input bit rnd_start);
    int len;
    len = $urandom_range(1, 4);
    send_frame(len, $urandom_range(0, len), rnd_start);
  endtask

  // mode 0 clean, 1 hit at 55, 2 one short of threshold at 55, 3 hit outside window at 49
  task automatic run_round(input int mode);
    int guard;
    bit done;
    int target, ncoll;
    guard = 0;
    done = 0;
    target = (mode == 3) ? 49 : 55;
    ncoll = (mode == 2) ? TH - 1 : TH;
    while (m_state == 2 && guard < 2000) begin
      if (mode != 0 && !done && m_depth == target && m_tick == 0) begin
        send_frame(ncoll + 1 + $urandom_range(0, 3), ncoll, 1'b0);
        done = 1;
      end else begin
        noise_frame(1'b1);
      end
      guard++;
    end
    check("round_end_state", int'(game_state_out), 3);
  endtask

  task automatic finish_result();
    int guard;
    guard = 0;
    while (m_state == 3 && guard < 100) begin
      noise_frame(1'b0);
      guard++;
    end
  endtask

  int modes[12] = '{0, 2, 3, 1, 0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    check_all();
    rst_in = 1;
    for (int i = 0; i < 6; i++) noise_frame(1'b0);
    check("idle_hold", int'(game_state_out), 0);

    cyc(1'b1, 1'b0, 1'b0);
    check("start_to_cd", int'(game_state_out), 1);
    for (int i = 0; i < CDF; i++) noise_frame(1'b0);
    check("cd_to_adv", int'(game_state_out), 2);

    for (int r = 0; r < 12; r++) begin
      run_round(modes[r]);
      if (r == 0) begin
        check("r0_pass_pulse", int'(round_pass_pulse_out), 1);
        check("r0_score", int'(score_out), 1);
        check("r0_idx", int'(wall_idx_out), 1);
      end
      if (r == 2) check("r2_fpt_speedup", int'(frames_per_tick_out), FPTMX - 1);
      if (r == 3) check("r3_lives", int'(lives_out), 2);
      if (r == 9) check("r9_idx_wrap", int'(wall_idx_out), 0);
      finish_result();
    end
    check("game_over_state", int'(game_state_out), 4);
    check("game_over_lives", int'(lives_out), 0);
    check("fpt_clamped", int'(frames_per_tick_out), FPTMN);
    check("total_passes", n_pass_seen, 9);
    check("total_fails", n_fail_seen, 3);
    check("final_score", int'(score_out), 9);

    for (int i = 0; i < 4; i++) noise_frame(1'b0);
    check("game_over_hold", int'(game_state_out), 4);
    cyc(1'b1, 1'b0, 1'b0);
    check("restart_state", int'(game_state_out), 1);
    check("restart_score", int'(score_out), 0);
    check("restart_lives", int'(lives_out), 3);
    for (int i = 0; i < CDF; i++) noise_frame(1'b0);
    for (int i = 0; i < 30; i++) noise_frame(1'b1);

`ifdef PAUSE_EN
    begin
      int d0, fr;
      d0 = m_depth;
      pause_in = 1;
      fr = 0;
      while (fr < 5) begin
        send_frame(3, 3, 1'b0);
        fr++;
      end
      check("pause_depth", int'(wall_depth_out), d0);
      pause_in = 0;
      for (int i = 0; i < 10; i++) noise_frame(1'b0);
    end
`endif

    check("pre_reset_state", int'(game_state_out), 2);
    rst_in = 0;
    #1;
    model_reset();
    check_all();
    check("async_rst_state", int'(game_state_out), 0);
    check("async_rst_lives", int'(lives_out), 3);
    @(negedge clk_in);
    rst_in = 1;
    cyc(1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
